main_memory_sequencer: RTL

Line-to-word sequencer between the memory bus interface and `sram_controller`. Takes a single cache-line read or write request and splits it into `BEATS` word accesses. For each access it drives the controller's `read`/`write` strobes and waits for `done`, then gathers the read words into one line response. It is the only master of the SRAM controller. It serialises line traffic so the controller only ever sees one strobe at a time, with an idle gap between accesses.

---
 rtl/main_memory_pkg.sv | 18 +
 rtl/mem_beat_counter.sv | 41 ++++
 rtl/register.sv | 36 +++
 rtl/main_memory_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/main_memory_pkg.sv
// Shared definitions for the main-memory line sequencer and its SRAM-side users.
package main_memory_pkg;

    // Default line geometry, shared with sram_controller users.
    localparam int DEFAULT_ADDR_WIDTH = 15;
    localparam int DEFAULT_WORD_WIDTH = 32;
    localparam int DEFAULT_BEATS      = 4;
    localparam int DEFAULT_BEAT_BITS  = 2;

    // Sequencer state encoding.
    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_GAP   = 2'd2,
        SEQ_RESP  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/mem_beat_counter.sv
// Beat index within a line: clear on accept, step once per completed beat.
module mem_beat_counter #(
    parameter int BEAT_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 en,
    output logic [BEAT_BITS-1:0] beat,
    output logic                 last
);

    logic [BEAT_BITS-1:0] beat_q;
    logic [BEAT_BITS-1:0] beat_d;

    // Clear has priority; the count only wraps by being cleared, never by stepping past the last beat.
    always_comb begin
        beat_d = beat_q;
        if (clr) begin
            beat_d = {BEAT_BITS{1'b0}};
        end else if (en && !last) begin
            beat_d = beat_q + BEAT_BITS'(1);
        end else begin
            beat_d = beat_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beat_q <= {BEAT_BITS{1'b0}};
        end else begin
            beat_q <= beat_d;
        end
    end

    assign beat = beat_q;
    // BEATS is a power of two, so the last beat is the all-ones index.
    assign last = &beat_q;

endmodule

// File: rtl/register.sv
// Generic load-enable register with synchronous active-low reset to zero.
module register #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Hold the stored value unless a load is requested.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end else begin
            q_d = q_q;
        end
    end

    // Storage flops, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q <= {WIDTH{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/main_memory_sequencer.sv
// Splits one cache-line request into BEATS single-word SRAM accesses,
// one strobe at a time with a one-cycle idle gap, and returns one line response.
module main_memory_sequencer
    import main_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int BEATS      = DEFAULT_BEATS,
    parameter int BEAT_BITS  = DEFAULT_BEAT_BITS
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_WIDTH-1:0]       req_addr,
    input  logic [WORD_WIDTH*BEATS-1:0] req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_write,
    output logic [WORD_WIDTH*BEATS-1:0] rsp_rdata,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [WORD_WIDTH-1:0]       mem_wdata,
    input  logic [WORD_WIDTH-1:0]       mem_rdata,
    input  logic                        mem_done
);

    localparam int LINE_AW = ADDR_WIDTH - BEAT_BITS;
    localparam int LINE_W  = WORD_WIDTH * BEATS;

    seq_state_e state_q, state_d;

    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [LINE_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  mem_read_q,  mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic                  latch_en_s;
    logic                  beat_clr_s;
    logic                  beat_en_s;
    logic [BEAT_BITS-1:0]  beat_s;
    logic [BEAT_BITS-1:0]  beat_inc_s;
    logic                  beat_last_s;
    logic [LINE_AW-1:0]    line_addr_s;
    logic                  op_write_s;
    logic [LINE_W-1:0]     line_wdata_s;
    logic                  unused_req_addr_s;

    // The word offset inside the line comes from the beat counter, not the request.
    assign unused_req_addr_s = ^req_addr[BEAT_BITS-1:0];
    assign beat_inc_s        = beat_s + BEAT_BITS'(1);

    register #(.WIDTH(LINE_AW)) u_line_addr_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (latch_en_s),
        .d       (req_addr[ADDR_WIDTH-1:BEAT_BITS]),
        .q       (line_addr_s)
    );

    register #(.WIDTH(1)) u_op_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (latch_en_s),
        .d       (req_write),
        .q       (op_write_s)
    );

    register #(.WIDTH(LINE_W)) u_wdata_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (latch_en_s),
        .d       (req_wdata),
        .q       (line_wdata_s)
    );

    mem_beat_counter #(.BEAT_BITS(BEAT_BITS)) u_beat_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (beat_clr_s),
        .en      (beat_en_s),
        .beat    (beat_s),
        .last    (beat_last_s)
    );

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        latch_en_s  = 1'b0;
        beat_clr_s  = 1'b0;
        beat_en_s   = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                // The request fields are used directly here since the latches load on this same edge.
                if (req_valid) begin
                    latch_en_s  = 1'b1;
                    beat_clr_s  = 1'b1;
                    state_d     = SEQ_ISSUE;
                    req_ready_d = 1'b0;
                    mem_read_d  = !req_write;
                    mem_write_d = req_write;
                    mem_addr_d  = {req_addr[ADDR_WIDTH-1:BEAT_BITS], BEAT_BITS'(0)};
                    mem_wdata_d = req_wdata[WORD_WIDTH-1:0];
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            SEQ_ISSUE: begin
                // Strobe, address and data hold until the controller reports completion.
                if (mem_done) begin
                    state_d     = SEQ_GAP;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (!op_write_s) begin
                        rsp_rdata_d[int'(beat_s)*WORD_WIDTH +: WORD_WIDTH] = mem_rdata;
                    end else begin
                        rsp_rdata_d = rsp_rdata_q;
                    end
                end else begin
                    state_d = SEQ_ISSUE;
                end
            end
            SEQ_GAP: begin
                // One strobe-free cycle lets the controller fall back to idle.
                if (beat_last_s) begin
                    state_d     = SEQ_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = op_write_s;
                end else begin
                    beat_en_s   = 1'b1;
                    state_d     = SEQ_ISSUE;
                    mem_read_d  = !op_write_s;
                    mem_write_d = op_write_s;
                    mem_addr_d  = {line_addr_s, beat_inc_s};
                    mem_wdata_d = line_wdata_s[int'(beat_inc_s)*WORD_WIDTH +: WORD_WIDTH];
                end
            end
            SEQ_RESP: begin
                if (rsp_ready) begin
                    state_d     = SEQ_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end else begin
                    state_d = SEQ_RESP;
                end
            end
            default: begin
                state_d     = SEQ_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset into IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= SEQ_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= {LINE_W{1'b0}};
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q <= {WORD_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
